wb_retire: RTL and testbench

Write-back end consumer of the MEM/WB pipeline register bundle. It owns the architectural HI/LO pair and the LLbit and commits them from the `wb_*` signals. It exposes their current values to the execute and memory stages. It also counts architectural commits and buffers GPR write-backs in a small trace FIFO drained over a valid/ready port for difftest/debug.

---
 rtl/wb_retire_if.sv | 58 +++++
 rtl/wb_retire.sv | 122 ++++++++++++
 tb/tb_wb_retire.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_retire_if.sv
// rtl/wb_retire_if.sv - MEM/WB retire bundle and trace port interface
//
// Purpose: groups every non-clock signal of wb_retire.
//   master : drives the MEM/WB bundle, flush, trace_ready and trace_clr,
//            and observes HI/LO, LLbit, commit_cnt and the trace FIFO head.
//   slave  : the wb_retire block itself.
// Signals:
//   wb_wd/wb_wreg/wb_wdata          GPR write-back of the committing bundle
//   wb_whilo/wb_hi/wb_lo            HI/LO write-back
//   wb_LLbit_we/wb_LLbit_value      LLbit write-back
//   flush                           exception/ERET flush (clears LLbit only)
//   hi_o/lo_o/LLbit_o               architectural state towards EX/MEM
//   commit_cnt                      architectural commit counter
//   trace_valid/trace_ready         trace FIFO head handshake
//   trace_wd/trace_wdata            trace FIFO head payload
//   trace_level/trace_overflow      occupancy and sticky drop flag
//   trace_clr                       clears trace_overflow
interface wb_retire_if #(
  parameter int TRACE_DEPTH = 4,
  parameter int CNT_W       = 32
);
  localparam int LVL_W = $clog2(TRACE_DEPTH) + 1;

  logic [4:0]       wb_wd;
  logic             wb_wreg;
  logic [31:0]      wb_wdata;
  logic             wb_whilo;
  logic [31:0]      wb_hi;
  logic [31:0]      wb_lo;
  logic             wb_LLbit_we;
  logic             wb_LLbit_value;
  logic             flush;
  logic [31:0]      hi_o;
  logic [31:0]      lo_o;
  logic             LLbit_o;
  logic [CNT_W-1:0] commit_cnt;
  logic             trace_valid;
  logic             trace_ready;
  logic [4:0]       trace_wd;
  logic [31:0]      trace_wdata;
  logic [LVL_W-1:0] trace_level;
  logic             trace_overflow;
  logic             trace_clr;

  modport master (
    output wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo,
    output wb_LLbit_we, wb_LLbit_value, flush, trace_ready, trace_clr,
    input  hi_o, lo_o, LLbit_o, commit_cnt,
    input  trace_valid, trace_wd, trace_wdata, trace_level, trace_overflow
  );

  modport slave (
    input  wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo,
    input  wb_LLbit_we, wb_LLbit_value, flush, trace_ready, trace_clr,
    output hi_o, lo_o, LLbit_o, commit_cnt,
    output trace_valid, trace_wd, trace_wdata, trace_level, trace_overflow
  );
endinterface

// File: rtl/wb_retire.sv
// rtl/wb_retire.sv - write-back retire stage: HI/LO, LLbit, commit counter, GPR trace FIFO
//
// Purpose: final consumer of the MEM/WB bundle. Owns HI/LO and LLbit,
// counts cycles with any architectural write, and queues non-$0 GPR
// write-backs in a small FIFO drained over a valid/ready port.
// Ports:
//   clk  : clock, all state on posedge
//   rst  : asynchronous active-high reset
//   bus  : wb_retire_if.slave (bundle inputs, state outputs, trace port)
module wb_retire #(
  parameter int TRACE_DEPTH = 4,
  parameter int CNT_W       = 32
) (
  input  logic          clk,
  input  logic          rst,
  wb_retire_if.slave    bus
);
  localparam int PTR_W = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
  localparam int LVL_W = $clog2(TRACE_DEPTH) + 1;

  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic             r_llbit;
  logic [CNT_W-1:0] r_cnt;

  logic [4:0]       r_mem_wd   [TRACE_DEPTH];
  logic [31:0]      r_mem_data [TRACE_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [LVL_W-1:0] r_level;
  logic             r_ovf;

  logic             w_llbit;
  logic             w_commit;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_accept;
  logic             w_drop;

  // LLbit next value doubles as the forwarded output so MEM sees a flush
  // or an SC/LL write-back in the same cycle it commits.
  always_comb begin
    w_llbit = r_llbit;
    if (bus.flush) begin
      w_llbit = 1'b0;
    end else if (bus.wb_LLbit_we) begin
      w_llbit = bus.wb_LLbit_value;
    end
  end

  assign w_commit = bus.wb_wreg | bus.wb_whilo | bus.wb_LLbit_we;

  // Trace FIFO control. When full, a push is only accepted if the head is
  // leaving in the same cycle; otherwise it is dropped and flagged.
  assign w_empty  = (r_level == '0);
  assign w_full   = (r_level == LVL_W'(TRACE_DEPTH));
  assign w_push   = bus.wb_wreg & (bus.wb_wd != 5'd0);
  assign w_pop    = ~w_empty & bus.trace_ready;
  assign w_accept = w_push & (~w_full | w_pop);
  assign w_drop   = w_push & w_full & ~w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi    <= '0;
      r_lo    <= '0;
      r_llbit <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (bus.wb_whilo) begin
        r_hi <= bus.wb_hi;
        r_lo <= bus.wb_lo;
      end
      r_llbit <= w_llbit;
      if (w_commit) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      r_level <= r_level + LVL_W'(w_accept) - LVL_W'(w_pop);
      // A drop in the same cycle as a clear leaves the flag set.
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (bus.trace_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Storage needs no reset: the head payload is masked while empty.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem_wd[r_wptr]   <= bus.wb_wd;
      r_mem_data[r_wptr] <= bus.wb_wdata;
    end
  end

  assign bus.hi_o           = r_hi;
  assign bus.lo_o           = r_lo;
  assign bus.LLbit_o        = w_llbit;
  assign bus.commit_cnt     = r_cnt;
  assign bus.trace_valid    = ~w_empty;
  assign bus.trace_wd       = w_empty ? 5'd0  : r_mem_wd[r_rptr];
  assign bus.trace_wdata    = w_empty ? 32'd0 : r_mem_data[r_rptr];
  assign bus.trace_level    = r_level;
  assign bus.trace_overflow = r_ovf;
endmodule

// File: tb/tb_wb_retire.sv
// tb/tb_wb_retire.sv - scoreboard testbench for wb_retire
module tb_wb_retire;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  wb_retire_if #(.TRACE_DEPTH(4), .CNT_W(4)) bus ();

  wb_retire #(.TRACE_DEPTH(4), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [36:0] exp_q[$];
  int n_chk  = 0;
  int n_fail = 0;
  int m_chk  = 0;
  int m_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wb_wd          = 5'd0;
    bus.wb_wreg        = 1'b0;
    bus.wb_wdata       = 32'd0;
    bus.wb_whilo       = 1'b0;
    bus.wb_hi          = 32'd0;
    bus.wb_lo          = 32'd0;
    bus.wb_LLbit_we    = 1'b0;
    bus.wb_LLbit_value = 1'b0;
    bus.flush          = 1'b0;
    bus.trace_clr      = 1'b0;
  endtask

  // Monitor: every accepted head is compared against the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.trace_valid && bus.trace_ready) begin
      m_chk++;
      if (exp_q.size() == 0) begin
        m_fail++;
        $display("FAIL trace_unexpected: got wd=%0d data=0x%08h expected none",
                 bus.trace_wd, bus.trace_wdata);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({bus.trace_wd, bus.trace_wdata} !== e) begin
          m_fail++;
          $display("FAIL trace_entry: got wd=%0d data=0x%08h expected wd=%0d data=0x%08h",
                   bus.trace_wd, bus.trace_wdata, e[36:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    idle();
    bus.trace_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", bus.hi_o, 32'd0);
    chk("rst_lo", bus.lo_o, 32'd0);
    chk("rst_llbit", 32'(bus.LLbit_o), 32'd0);
    chk("rst_cnt", 32'(bus.commit_cnt), 32'd0);
    chk("rst_valid", 32'(bus.trace_valid), 32'd0);
    chk("rst_level", 32'(bus.trace_level), 32'd0);
    chk("rst_ovf", 32'(bus.trace_overflow), 32'd0);
    chk("rst_wd", 32'(bus.trace_wd), 32'd0);
    rst = 1'b0;
    tick();

    // HI/LO write, then asynchronous reset mid-cycle.
    bus.wb_whilo = 1'b1;
    bus.wb_hi    = 32'h1234_5678;
    bus.wb_lo    = 32'h9ABC_DEF0;
    tick();
    idle();
    chk("hi_write", bus.hi_o, 32'h1234_5678);
    chk("lo_write", bus.lo_o, 32'h9ABC_DEF0);
    chk("cnt_one", 32'(bus.commit_cnt), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_hi", bus.hi_o, 32'd0);
    chk("async_lo", bus.lo_o, 32'd0);
    chk("async_cnt", 32'(bus.commit_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // LLbit forwarding and flush priority.
    bus.wb_LLbit_we    = 1'b1;
    bus.wb_LLbit_value = 1'b1;
    #1;
    chk("llbit_fwd", 32'(bus.LLbit_o), 32'd1);
    tick();
    idle();
    #1;
    chk("llbit_reg", 32'(bus.LLbit_o), 32'd1);
    bus.flush          = 1'b1;
    bus.wb_LLbit_we    = 1'b1;
    bus.wb_LLbit_value = 1'b1;
    #1;
    chk("llbit_flush_fwd", 32'(bus.LLbit_o), 32'd0);
    tick();
    idle();
    #1;
    chk("llbit_flush_reg", 32'(bus.LLbit_o), 32'd0);
    chk("cnt_llbit", 32'(bus.commit_cnt), 32'd2);

    // $0 writes are not traced.
    bus.wb_wreg  = 1'b1;
    bus.wb_wd    = 5'd0;
    bus.wb_wdata = 32'h0000_AAAA;
    tick();
    bus.wb_wd    = 5'd3;
    bus.wb_wdata = 32'h0000_0055;
    exp_q.push_back({5'd3, 32'h0000_0055});
    tick();
    idle();
    chk("filt_valid", 32'(bus.trace_valid), 32'd1);
    chk("filt_wd", 32'(bus.trace_wd), 32'd3);
    chk("filt_data", bus.trace_wdata, 32'h0000_0055);
    chk("filt_level", 32'(bus.trace_level), 32'd1);
    bus.trace_ready = 1'b1;
    tick();
    bus.trace_ready = 1'b0;
    chk("filt_drained", 32'(bus.trace_level), 32'd0);

    // Five pushes into a four-entry FIFO; clear coincides with the drop.
    for (int i = 1; i <= 5; i++) begin
      bus.wb_wreg   = 1'b1;
      bus.wb_wd     = 5'(i);
      bus.wb_wdata  = 32'h100 + 32'(i);
      bus.trace_clr = (i == 5);
      if (i <= 4) exp_q.push_back({5'(i), 32'h100 + 32'(i)});
      tick();
    end
    idle();
    chk("ovf_level", 32'(bus.trace_level), 32'd4);
    chk("ovf_flag", 32'(bus.trace_overflow), 32'd1);
    chk("ovf_head_wd", 32'(bus.trace_wd), 32'd1);
    chk("ovf_head_data", bus.trace_wdata, 32'h101);
    chk("cnt_pushes", 32'(bus.commit_cnt), 32'd9);
    bus.trace_clr = 1'b1;
    tick();
    idle();
    chk("ovf_cleared", 32'(bus.trace_overflow), 32'd0);

    // Full + push + pop.
    bus.trace_ready = 1'b1;
    bus.wb_wreg     = 1'b1;
    bus.wb_wd       = 5'd6;
    bus.wb_wdata    = 32'h106;
    exp_q.push_back({5'd6, 32'h106});
    tick();
    idle();
    bus.trace_ready = 1'b0;
    chk("full_pushpop_level", 32'(bus.trace_level), 32'd4);
    chk("full_pushpop_ovf", 32'(bus.trace_overflow), 32'd0);
    bus.trace_ready = 1'b1;
    for (int i = 0; i < 20 && bus.trace_level != 0; i++) tick();
    chk("drain_level", 32'(bus.trace_level), 32'd0);
    tick();
    chk("empty_ready_level", 32'(bus.trace_level), 32'd0);
    chk("empty_ready_valid", 32'(bus.trace_valid), 32'd0);
    chk("empty_wd", 32'(bus.trace_wd), 32'd0);
    bus.trace_ready = 1'b0;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // Counter wrap on a 4-bit build: 10 -> 15 -> 0.
    for (int i = 0; i < 5; i++) begin
      bus.wb_whilo = 1'b1;
      bus.wb_hi    = 32'(i);
      bus.wb_lo    = 32'(i) + 32'd100;
      tick();
    end
    idle();
    chk("cnt_max", 32'(bus.commit_cnt), 32'd15);
    chk("hi_last", bus.hi_o, 32'd4);
    bus.wb_whilo = 1'b1;
    bus.wb_hi    = 32'hDEAD_BEEF;
    tick();
    idle();
    chk("cnt_wrap", 32'(bus.commit_cnt), 32'd0);
    chk("hi_wrap", bus.hi_o, 32'hDEAD_BEEF);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk + m_chk, n_fail + m_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
